branch_predict_tracker: RTL and testbench

Holds every prediction the fetch stage takes from the branch cache until execute resolves that branch, in program order. On resolution it checks the actual outcome against the prediction and produces the branch-cache update strobe (iJUMP_* side of the branch cache). On a wrong prediction it also raises a mispredict redirect to fetch. It sits between fetch (push side), execute (resolve side) and the branch cache update port.

---
 rtl/branch_predict_tracker.sv | 167 ++++++++++++++++
 tb/tb_branch_predict_tracker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_tracker.sv
// In-order tracker of branch predictions between fetch and execute.
// Emits branch-cache training strobes and mispredict redirects on resolution.
module branch_predict_tracker #(
  parameter int DEPTH   = 8,
  parameter int DEPTH_N = 3
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iFLUSH,
  input  logic               iPUSH_STB,
  input  logic [31:0]        iPUSH_INST_ADDR,
  input  logic               iPUSH_HIT,
  input  logic               iPUSH_PREDICT_BRANCH,
  input  logic [31:0]        iPUSH_PREDICT_ADDR,
  output logic               oPUSH_FULL,
  input  logic               iRESOLVE_STB,
  input  logic               iRESOLVE_TAKEN,
  input  logic [31:0]        iRESOLVE_ADDR,
  output logic               oRESOLVE_ERR,
  output logic               oJUMP_STB,
  output logic               oJUMP_HIT,
  output logic [31:0]        oJUMP_ADDR,
  output logic [31:0]        oJUMP_INST_ADDR,
  output logic               oMISPREDICT,
  output logic [31:0]        oREDIRECT_ADDR,
  output logic               oEMPTY,
  output logic [DEPTH_N:0]   oCOUNT
);

  localparam logic [DEPTH_N:0] LP_FULL_CNT = (DEPTH_N+1)'(DEPTH);

  logic [31:0]        r_inst_addr [DEPTH];
  logic [31:0]        r_pred_addr [DEPTH];
  logic               r_hit       [DEPTH];
  logic               r_pred      [DEPTH];

  logic [DEPTH_N-1:0] r_wptr;
  logic [DEPTH_N-1:0] r_rptr;
  logic [DEPTH_N:0]   r_count;
  logic               r_empty;
  logic               r_full;

  logic               r_jump_stb;
  logic               r_jump_hit;
  logic [31:0]        r_jump_addr;
  logic [31:0]        r_jump_inst_addr;
  logic               r_mispredict;
  logic [31:0]        r_redirect_addr;
  logic               r_resolve_err;

  logic [31:0]        w_head_inst;
  logic [31:0]        w_head_pred_addr;
  logic               w_head_hit;
  logic               w_head_pred;
  logic               w_eff_pred;
  logic               w_mispredict;
  logic               w_resolve;
  logic               w_redirect;
  logic               w_push;
  logic [DEPTH_N-1:0] w_wptr_n;
  logic [DEPTH_N-1:0] w_rptr_n;
  logic [DEPTH_N:0]   w_count_n;

  assign w_head_inst      = r_inst_addr[r_rptr];
  assign w_head_pred_addr = r_pred_addr[r_rptr];
  assign w_head_hit       = r_hit[r_rptr];
  assign w_head_pred      = r_pred[r_rptr];

  assign w_eff_pred   = w_head_hit && w_head_pred;
  assign w_mispredict = (w_eff_pred != iRESOLVE_TAKEN) ||
                        (w_eff_pred && iRESOLVE_TAKEN && (w_head_pred_addr != iRESOLVE_ADDR));

  // Full/empty use the pre-edge state, so a pop never frees room for a same-cycle push.
  assign w_resolve  = !iFLUSH && iRESOLVE_STB && !r_empty;
  assign w_redirect = w_resolve && w_mispredict;
  assign w_push     = !iFLUSH && iPUSH_STB && !r_full && !w_redirect;

  always_comb begin
    w_wptr_n  = r_wptr;
    w_rptr_n  = r_rptr;
    w_count_n = r_count;
    if (iFLUSH) begin
      w_wptr_n  = '0;
      w_rptr_n  = '0;
      w_count_n = '0;
    end else begin
      if (w_resolve) begin
        w_rptr_n = r_rptr + 1'b1;
      end
      if (w_redirect) begin
        // Everything younger than the resolved branch is wrong-path.
        w_wptr_n  = r_rptr + 1'b1;
        w_count_n = '0;
      end else begin
        if (w_push) begin
          w_wptr_n = r_wptr + 1'b1;
        end
        case ({w_push, w_resolve})
          2'b10:   w_count_n = r_count + 1'b1;
          2'b01:   w_count_n = r_count - 1'b1;
          default: w_count_n = r_count;
        endcase
      end
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (w_push) begin
      r_inst_addr[r_wptr] <= iPUSH_INST_ADDR;
      r_pred_addr[r_wptr] <= iPUSH_PREDICT_ADDR;
      r_hit[r_wptr]       <= iPUSH_HIT;
      r_pred[r_wptr]      <= iPUSH_PREDICT_BRANCH;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_n;
      r_rptr  <= w_rptr_n;
      r_count <= w_count_n;
      r_empty <= (w_count_n == '0);
      r_full  <= (w_count_n == LP_FULL_CNT);
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_jump_stb       <= 1'b0;
      r_jump_hit       <= 1'b0;
      r_jump_addr      <= '0;
      r_jump_inst_addr <= '0;
      r_mispredict     <= 1'b0;
      r_redirect_addr  <= '0;
      r_resolve_err    <= 1'b0;
    end else begin
      r_jump_stb    <= w_resolve && (iRESOLVE_TAKEN || w_head_hit);
      r_jump_hit    <= w_resolve && !iRESOLVE_TAKEN;
      r_mispredict  <= w_redirect;
      r_resolve_err <= !iFLUSH && iRESOLVE_STB && r_empty;
      if (w_resolve) begin
        r_jump_addr      <= iRESOLVE_TAKEN ? iRESOLVE_ADDR : w_head_pred_addr;
        r_jump_inst_addr <= w_head_inst;
      end
      if (w_redirect) begin
        r_redirect_addr <= iRESOLVE_TAKEN ? iRESOLVE_ADDR : (w_head_inst + 32'd4);
      end
    end
  end

  assign oPUSH_FULL      = r_full;
  assign oEMPTY          = r_empty;
  assign oCOUNT          = r_count;
  assign oJUMP_STB       = r_jump_stb;
  assign oJUMP_HIT       = r_jump_hit;
  assign oJUMP_ADDR      = r_jump_addr;
  assign oJUMP_INST_ADDR = r_jump_inst_addr;
  assign oMISPREDICT     = r_mispredict;
  assign oREDIRECT_ADDR  = r_redirect_addr;
  assign oRESOLVE_ERR    = r_resolve_err;

endmodule

// File: tb/tb_branch_predict_tracker.sv
// Directed self-checking bench for branch_predict_tracker.
module tb_branch_predict_tracker;

  logic        iCLOCK;
  logic        inRESET;
  logic        iFLUSH;
  logic        iPUSH_STB;
  logic [31:0] iPUSH_INST_ADDR;
  logic        iPUSH_HIT;
  logic        iPUSH_PREDICT_BRANCH;
  logic [31:0] iPUSH_PREDICT_ADDR;
  logic        oPUSH_FULL;
  logic        iRESOLVE_STB;
  logic        iRESOLVE_TAKEN;
  logic [31:0] iRESOLVE_ADDR;
  logic        oRESOLVE_ERR;
  logic        oJUMP_STB;
  logic        oJUMP_HIT;
  logic [31:0] oJUMP_ADDR;
  logic [31:0] oJUMP_INST_ADDR;
  logic        oMISPREDICT;
  logic [31:0] oREDIRECT_ADDR;
  logic        oEMPTY;
  logic [3:0]  oCOUNT;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  logic [31:0] q_inst[$];

  branch_predict_tracker #(.DEPTH(8), .DEPTH_N(3)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iFLUSH(iFLUSH),
    .iPUSH_STB(iPUSH_STB), .iPUSH_INST_ADDR(iPUSH_INST_ADDR), .iPUSH_HIT(iPUSH_HIT),
    .iPUSH_PREDICT_BRANCH(iPUSH_PREDICT_BRANCH), .iPUSH_PREDICT_ADDR(iPUSH_PREDICT_ADDR),
    .oPUSH_FULL(oPUSH_FULL), .iRESOLVE_STB(iRESOLVE_STB), .iRESOLVE_TAKEN(iRESOLVE_TAKEN),
    .iRESOLVE_ADDR(iRESOLVE_ADDR), .oRESOLVE_ERR(oRESOLVE_ERR), .oJUMP_STB(oJUMP_STB),
    .oJUMP_HIT(oJUMP_HIT), .oJUMP_ADDR(oJUMP_ADDR), .oJUMP_INST_ADDR(oJUMP_INST_ADDR),
    .oMISPREDICT(oMISPREDICT), .oREDIRECT_ADDR(oREDIRECT_ADDR), .oEMPTY(oEMPTY),
    .oCOUNT(oCOUNT)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic push, input logic [31:0] ia, input logic hit,
                      input logic pr, input logic [31:0] pa, input logic res,
                      input logic tk, input logic [31:0] ra, input logic fl);
    iPUSH_STB = push; iPUSH_INST_ADDR = ia; iPUSH_HIT = hit;
    iPUSH_PREDICT_BRANCH = pr; iPUSH_PREDICT_ADDR = pa;
    iRESOLVE_STB = res; iRESOLVE_TAKEN = tk; iRESOLVE_ADDR = ra; iFLUSH = fl;
    @(posedge iCLOCK);
    #1;
    iPUSH_STB = 1'b0; iRESOLVE_STB = 1'b0; iFLUSH = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_inst;
    inRESET = 1'b0;
    iFLUSH = 0; iPUSH_STB = 0; iPUSH_INST_ADDR = '0; iPUSH_HIT = 0;
    iPUSH_PREDICT_BRANCH = 0; iPUSH_PREDICT_ADDR = '0;
    iRESOLVE_STB = 0; iRESOLVE_TAKEN = 0; iRESOLVE_ADDR = '0;
    #23;
    chk("rst_empty", 32'(oEMPTY), 32'd1);
    chk("rst_count", 32'(oCOUNT), 32'd0);
    chk("rst_full",  32'(oPUSH_FULL), 32'd0);
    chk("rst_pulses", {27'd0, oJUMP_STB, oJUMP_HIT, oMISPREDICT, oRESOLVE_ERR, 1'b0}, 32'd0);
    chk("rst_addrs", oJUMP_ADDR | oJUMP_INST_ADDR | oREDIRECT_ADDR, 32'd0);
    @(negedge iCLOCK);
    inRESET = 1'b1;
    @(posedge iCLOCK); #1;

    // Fill: 8 correctly predicted taken branches, target = inst + 0x1000
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h1000 + 32'(i*16), 1'b1, 1'b1, 32'h2000 + 32'(i*16), 1'b0, 1'b0, '0, 1'b0);
      q_inst.push_back(32'h1000 + 32'(i*16));
    end
    chk("fill_full", 32'(oPUSH_FULL), 32'd1);
    chk("fill_count", 32'(oCOUNT), 32'd8);
    step(1'b1, 32'hDEAD0000, 1'b1, 1'b1, 32'hDEAD1000, 1'b0, 1'b0, '0, 1'b0);
    chk("drop_count", 32'(oCOUNT), 32'd8);

    // Push while full with a pop in the same cycle: push still dropped
    exp_inst = q_inst.pop_front();
    step(1'b1, 32'hBEEF0000, 1'b1, 1'b1, 32'hBEEF1000, 1'b1, 1'b1, exp_inst + 32'h1000, 1'b0);
    chk("fullpop_count", 32'(oCOUNT), 32'd7);
    chk("fullpop_inst", oJUMP_INST_ADDR, exp_inst);
    chk("fullpop_full", 32'(oPUSH_FULL), 32'd0);

    // Steady push+pop across pointer wrap
    for (int k = 0; k < 20; k++) begin
      exp_inst = q_inst.pop_front();
      step(1'b1, 32'h3000 + 32'(k*16), 1'b1, 1'b1, 32'h4000 + 32'(k*16),
           1'b1, 1'b1, exp_inst + 32'h1000, 1'b0);
      q_inst.push_back(32'h3000 + 32'(k*16));
      chk("wrap_inst", oJUMP_INST_ADDR, exp_inst);
      chk("wrap_addr", oJUMP_ADDR, exp_inst + 32'h1000);
      chk("wrap_stb", 32'(oJUMP_STB), 32'd1);
      chk("wrap_mis", 32'(oMISPREDICT), 32'd0);
      chk("wrap_count", 32'(oCOUNT), 32'd7);
    end

    // Drain back-to-back
    for (int k = 0; k < 7; k++) begin
      exp_inst = q_inst.pop_front();
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, exp_inst + 32'h1000, 1'b0);
      chk("drain_inst", oJUMP_INST_ADDR, exp_inst);
      chk("drain_count", 32'(oCOUNT), 32'(6 - k));
    end
    chk("drain_empty", 32'(oEMPTY), 32'd1);
    idle();
    chk("drain_stb_off", 32'(oJUMP_STB), 32'd0);

    // Correct taken prediction
    step(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h200, 1'b0);
    chk("tk_stb", 32'(oJUMP_STB), 32'd1);
    chk("tk_hit", 32'(oJUMP_HIT), 32'd0);
    chk("tk_addr", oJUMP_ADDR, 32'h200);
    chk("tk_inst", oJUMP_INST_ADDR, 32'h100);
    chk("tk_mis", 32'(oMISPREDICT), 32'd0);
    idle();
    chk("tk_pulse", 32'(oJUMP_STB), 32'd0);

    // Predicted taken, actually not taken
    step(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("nt_stb", 32'(oJUMP_STB), 32'd1);
    chk("nt_hit", 32'(oJUMP_HIT), 32'd1);
    chk("nt_addr", oJUMP_ADDR, 32'h200);
    chk("nt_mis", 32'(oMISPREDICT), 32'd1);
    chk("nt_redir", oREDIRECT_ADDR, 32'h104);
    idle();
    chk("nt_mis_pulse", 32'(oMISPREDICT), 32'd0);

    // Miss then taken: younger entries squashed
    step(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 32'h404, 1'b1, 1'b1, 32'h900, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 32'h408, 1'b1, 1'b1, 32'h904, 1'b0, 1'b0, '0, 1'b0);
    chk("m3_count", 32'(oCOUNT), 32'd3);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h300, 1'b0);
    chk("m3_mis", 32'(oMISPREDICT), 32'd1);
    chk("m3_redir", oREDIRECT_ADDR, 32'h300);
    chk("m3_count0", 32'(oCOUNT), 32'd0);
    chk("m3_stb", 32'(oJUMP_STB), 32'd1);
    chk("m3_addr", oJUMP_ADDR, 32'h300);

    // Resolve on empty
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h500, 1'b0);
    chk("err_pulse", 32'(oRESOLVE_ERR), 32'd1);
    chk("err_nostb", 32'(oJUMP_STB), 32'd0);
    idle();
    chk("err_off", 32'(oRESOLVE_ERR), 32'd0);

    // Not-taken miss: no update; hit not-taken correct: update, no mispredict
    step(1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 32'h700, 1'b1, 1'b0, 32'h780, 1'b1, 1'b0, '0, 1'b0);
    chk("ntmiss_stb", 32'(oJUMP_STB), 32'd0);
    chk("ntmiss_mis", 32'(oMISPREDICT), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("hitnt_stb", 32'(oJUMP_STB), 32'd1);
    chk("hitnt_addr", oJUMP_ADDR, 32'h780);
    chk("hitnt_inst", oJUMP_INST_ADDR, 32'h700);
    chk("hitnt_mis", 32'(oMISPREDICT), 32'd0);

    // Wrong target, with a push in the same cycle that must be discarded
    step(1'b1, 32'h800, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 32'h804, 1'b1, 1'b1, 32'h208, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 32'h808, 1'b1, 1'b1, 32'h20C, 1'b1, 1'b1, 32'h240, 1'b0);
    chk("tgt_mis", 32'(oMISPREDICT), 32'd1);
    chk("tgt_redir", oREDIRECT_ADDR, 32'h240);
    chk("tgt_count", 32'(oCOUNT), 32'd0);

    // Redirect address wraps
    step(1'b1, 32'hFFFFFFFC, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("wrap_redir", oREDIRECT_ADDR, 32'h0);
    chk("wrap_mis1", 32'(oMISPREDICT), 32'd1);

    // Flush beats simultaneous push and resolve
    step(1'b1, 32'hA00, 1'b1, 1'b1, 32'hB00, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 32'hA04, 1'b1, 1'b1, 32'hB04, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 32'hA08, 1'b1, 1'b1, 32'hB08, 1'b1, 1'b0, '0, 1'b1);
    chk("fl_count", 32'(oCOUNT), 32'd0);
    chk("fl_empty", 32'(oEMPTY), 32'd1);
    chk("fl_stb", 32'(oJUMP_STB), 32'd0);
    chk("fl_mis", 32'(oMISPREDICT), 32'd0);
    chk("fl_err", 32'(oRESOLVE_ERR), 32'd0);

    // Queue still usable after flush
    step(1'b1, 32'hC00, 1'b1, 1'b1, 32'hD00, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'hD00, 1'b0);
    chk("pf_inst", oJUMP_INST_ADDR, 32'hC00);
    chk("pf_mis", 32'(oMISPREDICT), 32'd0);

    // Asynchronous reset mid-operation
    step(1'b1, 32'hE00, 1'b1, 1'b1, 32'hF00, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 32'hE04, 1'b1, 1'b1, 32'hF04, 1'b1, 1'b0, '0, 1'b0);
    chk("pre_rst_mis", 32'(oMISPREDICT), 32'd1);
    #2 inRESET = 1'b0;
    #1;
    chk("arst_count", 32'(oCOUNT), 32'd0);
    chk("arst_empty", 32'(oEMPTY), 32'd1);
    chk("arst_mis", 32'(oMISPREDICT), 32'd0);
    @(negedge iCLOCK);
    inRESET = 1'b1;
    idle();
    chk("rel_pulses", {28'd0, oJUMP_STB, oJUMP_HIT, oMISPREDICT, oRESOLVE_ERR}, 32'd0);
    chk("rel_count", 32'(oCOUNT), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
